// File: rtl/clock_divider_bank_pkg.sv
// Shared defaults and helpers for the clock divider bank.
package clock_divider_bank_pkg;

    localparam int unsigned DEFAULT_NUM_CH = 4;
    localparam int unsigned DEFAULT_CNT_W  = 22;
    localparam int unsigned DEFAULT_DIV    = 2097152;

    // Width of the channel index; never less than one bit.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clock_divider_bank_div_channel.sv
// One divider channel: free-running counter, shadowed divisor, tick and
// 50% duty clock output. A new divisor waits in the shadow register until
// the current period completes (or is applied at once while disabled).
module div_channel
    import clock_divider_bank_pkg::*;
#(
    parameter int unsigned CNT_W   = DEFAULT_CNT_W,
    parameter int unsigned DEF_DIV = DEFAULT_DIV
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_div,
    output logic             o_pending,
    output logic             o_tick,
    output logic             o_clk_out
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_shadow;
    logic             r_pending;
    logic             r_tick;
    logic             r_clk_out;

    logic [CNT_W-1:0] w_div_eff;
    logic             w_wrap;

    // A divisor of zero behaves as one.
    assign w_div_eff = (r_div_act == '0) ? CNT_W'(1) : r_div_act;
    assign w_wrap    = i_en && (r_cnt >= (w_div_eff - CNT_W'(1)));

    // Counter, divisor hand-over and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt        <= '0;
            r_div_act    <= RST_DIV;
            r_div_shadow <= RST_DIV;
            r_pending    <= 1'b0;
            r_tick       <= 1'b0;
            r_clk_out    <= 1'b0;
        end else begin
            if (!i_en) begin
                r_cnt     <= '0;
                r_tick    <= 1'b0;
                r_clk_out <= 1'b0;
                if (r_pending) begin
                    r_div_act <= r_div_shadow;
                    r_pending <= 1'b0;
                end
            end else if (w_wrap) begin
                r_cnt     <= '0;
                r_tick    <= 1'b1;
                r_clk_out <= ~r_clk_out;
                if (r_pending) begin
                    r_div_act <= r_div_shadow;
                    r_pending <= 1'b0;
                end
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_tick <= 1'b0;
            end
            // A write is only accepted while nothing is pending, so it never
            // collides with the hand-over above; a write on a wrap edge is
            // therefore applied at the following wrap.
            if (i_wr) begin
                r_div_shadow <= i_wr_div;
                r_pending    <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_tick    = r_tick;
    assign o_clk_out = r_clk_out;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independent clock dividers with a shared divisor-update port.
module clock_divider_bank
    import clock_divider_bank_pkg::*;
#(
    parameter int unsigned NUM_CH  = DEFAULT_NUM_CH,
    parameter int unsigned CNT_W   = DEFAULT_CNT_W,
    parameter int unsigned DEF_DIV = DEFAULT_DIV
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CH-1:0]               ch_en,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [ch_idx_w(NUM_CH)-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]                cfg_div,
    output logic [NUM_CH-1:0]               tick,
    output logic [NUM_CH-1:0]               clk_out
);

    localparam int unsigned CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_wr;
    logic              w_accept;

    // Out-of-range indices match no channel, so they read as not ready.
    assign cfg_ready = rst_n & |(w_hit & ~w_pending);
    assign w_accept  = cfg_valid & cfg_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_hit[i] = (cfg_ch == CH_W'(i));
        assign w_wr[i]  = w_accept & w_hit[i];

        div_channel #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .i_clk     (clk),
            .i_rst_n   (rst_n),
            .i_en      (ch_en[i]),
            .i_wr      (w_wr[i]),
            .i_wr_div  (cfg_div),
            .o_pending (w_pending[i]),
            .o_tick    (tick[i]),
            .o_clk_out (clk_out[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Testbench for clock_divider_bank: directed scenarios with literal
// expectations plus a randomized run checked against a period-level model.
module tb_clock_divider_bank;

    localparam int unsigned NCH  = 4;
    localparam int unsigned CW   = 8;
    localparam int unsigned DDIV = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NCH-1:0]  ch_en = '0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [1:0]      cfg_ch = '0;
    logic [CW-1:0]   cfg_div = '0;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  clk_out;

    logic            cfg_ready3;
    logic [2:0]      tick3;
    logic [2:0]      clk_out3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    clock_divider_bank #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(DDIV)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .tick      (tick),
        .clk_out   (clk_out)
    );

    // Three-channel instance: index 3 is out of range here.
    clock_divider_bank #(.NUM_CH(3), .CNT_W(CW), .DEF_DIV(DDIV)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_en     (ch_en[2:0]),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready3),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .tick      (tick3),
        .clk_out   (clk_out3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each channel tracks how many enabled cycles of the current period have
    // elapsed; a period ends when that reaches the effective divisor.
    int       m_el [NCH];
    int       m_act[NCH];
    int       m_sh [NCH];
    bit       m_pend[NCH];
    logic [NCH-1:0] e_tick = '0;
    logic [NCH-1:0] e_clk  = '0;
    bit       m_ok = 0;
    int       acc_ch;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_el[i] = 0; m_act[i] = DDIV; m_sh[i] = DDIV; m_pend[i] = 0;
            end
            e_tick = '0;
            e_clk  = '0;
            m_ok   = 1;
        end else begin
            acc_ch = (cfg_valid && !m_pend[cfg_ch]) ? int'(cfg_ch) : -1;
            for (int i = 0; i < NCH; i++) begin
                if (!ch_en[i]) begin
                    m_el[i] = 0; e_tick[i] = 1'b0; e_clk[i] = 1'b0;
                    if (m_pend[i]) begin m_act[i] = m_sh[i]; m_pend[i] = 0; end
                end else begin
                    m_el[i]++;
                    if (m_el[i] >= eff(m_act[i])) begin
                        m_el[i] = 0; e_tick[i] = 1'b1; e_clk[i] = ~e_clk[i];
                        if (m_pend[i]) begin m_act[i] = m_sh[i]; m_pend[i] = 0; end
                    end else begin
                        e_tick[i] = 1'b0;
                    end
                end
                if (acc_ch == i) begin m_sh[i] = int'(cfg_div); m_pend[i] = 1; end
            end
        end
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_tick", 32'(tick), 32'(e_tick));
            chk("m_clk_out", 32'(clk_out), 32'(e_clk));
            chk("m_ready", 32'(cfg_ready), 32'(rst_n && !m_pend[cfg_ch]));
            chk("m3_tick", 32'(tick3), 32'(e_tick[2:0]));
            chk("m3_clk_out", 32'(clk_out3), 32'(e_clk[2:0]));
            chk("m3_ready", 32'(cfg_ready3), 32'(rst_n && cfg_ch != 2'd3 && !m_pend[cfg_ch]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int d);
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_div = CW'(d);
    endtask

    initial begin
        // Reset state
        step(2);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_ready", 32'(cfg_ready), 0);

        // Channel 0 at default divisor 4
        rst_n = 1'b1; ch_en = 4'b0001;
        step(3); chk("d4_tick_early", 32'(tick), 0);
        step(1); chk("d4_tick1", 32'(tick), 32'h1); chk("d4_clk1", 32'(clk_out), 32'h1);
        step(4); chk("d4_tick2", 32'(tick), 32'h1); chk("d4_clk2", 32'(clk_out), 0);
        chk("d4_ready", 32'(cfg_ready), 1);

        // Mid-period update on ch0: d=4 -> d=2 written at cnt=1
        step(1); chk("upd_tick0", 32'(tick[0]), 0);
        wr(0, 2); #1 chk("upd_ready_pre", 32'(cfg_ready), 1);
        step(1); cfg_valid = 1'b0; #1 chk("upd_ready_pend", 32'(cfg_ready), 0);
        step(1); chk("upd_tick_c3", 32'(tick[0]), 0); chk("upd_ready_c3", 32'(cfg_ready), 0);
        step(1); chk("upd_tick_old", 32'(tick[0]), 1); chk("upd_ready_done", 32'(cfg_ready), 1);
        step(1); chk("upd_tick_n1", 32'(tick[0]), 0);
        step(1); chk("upd_tick_n2", 32'(tick[0]), 1);

        // Update on the exact wrap edge of ch1 (d=5 -> d=3)
        wr(1, 5); step(1); cfg_valid = 1'b0; step(1);
        ch_en[1] = 1'b1;
        step(4); chk("wrap_t4", 32'(tick[1]), 0);
        wr(1, 3); #1 chk("wrap_ready", 32'(cfg_ready), 1);
        step(1); chk("wrap_t5", 32'(tick[1]), 1);
        cfg_valid = 1'b0; #1 chk("wrap_pend", 32'(cfg_ready), 0);
        step(4); chk("wrap_t9", 32'(tick[1]), 0);
        step(1); chk("wrap_t10", 32'(tick[1]), 1); chk("wrap_ready2", 32'(cfg_ready), 1);
        step(2); chk("wrap_t12", 32'(tick[1]), 0);
        step(1); chk("wrap_t13", 32'(tick[1]), 1);

        // d=0 and d=1 on ch2
        wr(2, 0); step(1); cfg_valid = 1'b0; step(1);
        ch_en[2] = 1'b1;
        step(1); chk("d0_tick_a", 32'(tick[2]), 1); chk("d0_clk_a", 32'(clk_out[2]), 1);
        step(1); chk("d0_tick_b", 32'(tick[2]), 1); chk("d0_clk_b", 32'(clk_out[2]), 0);
        wr(2, 1);
        step(1); cfg_valid = 1'b0; chk("d1_tick_a", 32'(tick[2]), 1); chk("d1_clk_a", 32'(clk_out[2]), 1);
        step(1); chk("d1_tick_b", 32'(tick[2]), 1); chk("d1_clk_b", 32'(clk_out[2]), 0);
        step(1); chk("d1_tick_c", 32'(tick[2]), 1); chk("d1_clk_c", 32'(clk_out[2]), 1);

        // Disable ch3 with a pending update, then re-enable
        ch_en[3] = 1'b1;
        step(2);
        wr(3, 6); step(1); cfg_valid = 1'b0;
        #1 chk("dis_ready_pend", 32'(cfg_ready), 0);
        ch_en[3] = 1'b0;
        step(1); chk("dis_tick", 32'(tick[3]), 0); chk("dis_clk", 32'(clk_out[3]), 0);
        chk("dis_ready", 32'(cfg_ready), 1);
        ch_en[3] = 1'b1;
        step(5); chk("ren_t5", 32'(tick[3]), 0);
        step(1); chk("ren_t6", 32'(tick[3]), 1);

        // Reset mid-count with updates pending on all channels
        for (int i = 0; i < NCH; i++) begin wr(i, 9); step(1); end
        cfg_valid = 1'b0; rst_n = 1'b0;
        step(1); chk("mrst_tick", 32'(tick), 0); chk("mrst_clk", 32'(clk_out), 0);
        chk("mrst_ready", 32'(cfg_ready), 0);
        rst_n = 1'b1; ch_en = 4'b1111;
        step(3); chk("mrst_t3", 32'(tick), 0);
        step(1); chk("mrst_t4", 32'(tick), 32'hF); chk("mrst_clk4", 32'(clk_out), 32'hF);

        // Randomized run
        ch_en = 4'hF;
        for (int n = 0; n < 4000; n++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 19) == 0) ch_en = 4'($urandom);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch    = 2'($urandom);
            cfg_div   = CW'($urandom_range(0, 7));
            step(1);
        end
        cfg_valid = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
